// File: rtl/regfile_master_pkg.sv
// Shared encodings for the register-file master: command opcodes, controller
// states and the strobe-counter width helper.
package regfile_master_pkg;

    typedef enum logic [1:0] {
        OP_RD  = 2'b00,
        OP_WR  = 2'b01,
        OP_CLR = 2'b10,
        OP_ILL = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR     = 3'd1,
        WR_REC = 3'd2,
        RD     = 3'd3,
        CLR    = 3'd4,
        RSP    = 3'd5
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One spare bit so the largest load value never needs the top code.
    function automatic int cnt_width(input int wr_cycles, input int rd_lat);
        return $clog2(max_int(wr_cycles, rd_lat)) + 1;
    endfunction

endpackage

// File: rtl/regfile_master_timer.sv
// Loadable down-counter timing the rf_wr / rf_rd strobes; done marks the
// last strobe cycle (count reached zero).
import regfile_master_pkg::*;

module regfile_master_timer #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          done
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: load wins, otherwise step down and stop at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != {CW{1'b0}})) begin
            cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign done = (cnt_q == {CW{1'b0}});

endmodule

// File: rtl/regfile_master.sv
// Command-driven initiator for a small register file: sequences rd/wr strobes
// with fixed timing and returns exactly one response beat per command.
import regfile_master_pkg::*;

module regfile_master #(
    parameter int            DW        = 8,
    parameter int            AW        = 2,
    parameter int            WR_CYCLES = 1,
    parameter int            RD_LAT    = 1,
    parameter logic [DW-1:0] CLR_VAL   = 8'h00
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic [AW-1:0] rf_addr,
    output logic          rf_rd,
    output logic          rf_wr,
    output logic [DW-1:0] rf_data_in,
    input  logic [DW-1:0] rf_data_out
);

    localparam int            CW        = cnt_width(WR_CYCLES, RD_LAT);
    localparam logic [CW-1:0] WR_LOAD   = CW'(WR_CYCLES - 1);
    localparam logic [CW-1:0] RD_LOAD   = CW'(RD_LAT - 1);
    localparam logic [AW-1:0] ADDR_LAST = {AW{1'b1}};
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1'b1);

    state_e        state_q, state_d;
    op_e           op_q, op_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rf_rd_q, rf_rd_d;
    logic          rf_wr_q, rf_wr_d;

    logic          tmr_load;
    logic [CW-1:0] tmr_val;
    logic          tmr_en;
    logic [CW-1:0] tmr_cnt;
    logic          tmr_done;

    regfile_master_timer #(.CW(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .cnt      (tmr_cnt),
        .done     (tmr_done)
    );

    // Next-state, command latching and strobe/response flag decode.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        tmr_load = 1'b0;
        tmr_val  = WR_LOAD;
        tmr_en   = 1'b0;

        case (state_q)
            IDLE: begin
                // cmd_ready_q gates acceptance so the first post-reset cycle is idle.
                if (cmd_valid && cmd_ready_q) begin
                    op_d    = op_e'(cmd_op);
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    rdata_d = {DW{1'b0}};
                    err_d   = 1'b0;
                    case (op_e'(cmd_op))
                        OP_RD: begin
                            state_d  = RD;
                            tmr_load = 1'b1;
                            tmr_val  = RD_LOAD;
                        end
                        OP_WR: begin
                            state_d  = WR;
                            tmr_load = 1'b1;
                        end
                        OP_CLR: begin
                            state_d  = CLR;
                            addr_d   = {AW{1'b0}};
                            wdata_d  = CLR_VAL;
                            tmr_load = 1'b1;
                        end
                        default: begin
                            state_d = RSP;
                            err_d   = 1'b1;
                        end
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            WR, CLR: begin
                tmr_en = 1'b1;
                if (tmr_done) begin
                    state_d = WR_REC;
                end else begin
                    state_d = state_q;
                end
            end
            WR_REC: begin
                if ((op_q == OP_CLR) && (addr_q != ADDR_LAST)) begin
                    addr_d   = addr_q + ADDR_ONE;
                    state_d  = CLR;
                    tmr_load = 1'b1;
                end else if (op_q == OP_CLR) begin
                    addr_d  = addr_q + ADDR_ONE;
                    state_d = RSP;
                end else begin
                    state_d = RSP;
                end
            end
            RD: begin
                tmr_en = 1'b1;
                if (tmr_done) begin
                    rdata_d = rf_data_out;
                    state_d = RSP;
                end else begin
                    state_d = RD;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    rdata_d = {DW{1'b0}};
                    err_d   = 1'b0;
                end else begin
                    state_d = RSP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Interface flags are decoded from the next state so they are registered.
        cmd_ready_d = (state_d == IDLE);
        rf_wr_d     = (state_d == WR) || (state_d == CLR);
        rf_rd_d     = (state_d == RD);
        rsp_valid_d = (state_d == RSP);
    end

    // State and output registers; reset aborts any command in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= OP_RD;
            addr_q      <= {AW{1'b0}};
            wdata_q     <= {DW{1'b0}};
            rdata_q     <= {DW{1'b0}};
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rf_rd_q     <= 1'b0;
            rf_wr_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rf_rd_q     <= rf_rd_d;
            rf_wr_q     <= rf_wr_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rdata_q;
    assign rsp_err    = err_q;
    assign rf_addr    = addr_q;
    assign rf_data_in = wdata_q;
    assign rf_rd      = rf_rd_q;
    assign rf_wr      = rf_wr_q;

endmodule

// File: tb/tb_regfile_master.sv
// Directed bench for regfile_master with a behavioural 4x8 register file
// attached to the rf_* port.
module tb_regfile_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [1:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic [1:0] rf_addr;
    logic       rf_rd;
    logic       rf_wr;
    logic [7:0] rf_data_in;
    logic [7:0] rf_data_out;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [4];
    int         wr_cnt = 0;
    int         rd_cnt = 0;
    int         both_cnt = 0;
    logic [1:0] wr_log [64];

    regfile_master dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rf_addr     (rf_addr),
        .rf_rd       (rf_rd),
        .rf_wr       (rf_wr),
        .rf_data_in  (rf_data_in),
        .rf_data_out (rf_data_out)
    );

    always #5 clk = ~clk;

    // Register file model plus strobe monitor.
    assign rf_data_out = rf_rd ? mem[rf_addr] : 8'h00;
    always @(posedge clk) begin
        if (rf_wr) begin
            mem[rf_addr] <= rf_data_in;
            wr_log[wr_cnt % 64] = rf_addr;
            wr_cnt = wr_cnt + 1;
        end
        if (rf_rd) rd_cnt = rd_cnt + 1;
        if (rf_rd && rf_wr) both_cnt = both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command with rsp_ready high and check timing, response and strobes.
    task automatic issue(input logic [1:0] op, input logic [1:0] a, input logic [7:0] d,
                         input int exp_lat, input logic [7:0] exp_rdata, input logic exp_err,
                         input int exp_wr, input int exp_rd);
        int wr0, rd0, lat;
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = d;
        wr0 = wr_cnt; rd0 = rd_cnt;
        tick();
        cmd_valid = 1'b0;
        if (op == 2'b00) check("rd_strobe_addr", {rf_rd, 6'd0, rf_addr}, {1'b1, 6'd0, a});
        if (op == 2'b01) check("wr_strobe", {rf_wr, rf_addr, rf_data_in}, {1'b1, a, d});
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 30) begin
            tick();
            lat++;
        end
        check("rsp_latency", lat, exp_lat);
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("rsp_err", rsp_err, exp_err);
        check("cmd_ready_busy", cmd_ready, 0);
        check("wr_cycles", wr_cnt - wr0, exp_wr);
        check("rd_cycles", rd_cnt - rd0, exp_rd);
        tick();
        check("post_rsp_idle", {rsp_valid, cmd_ready}, 2'b01);
    endtask

    initial begin
        int base;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 2'd0;
        cmd_wdata = 8'h00; rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) mem[i] = 8'hEE;

        // Reset state and release.
        repeat (3) tick();
        check("reset_outputs", {cmd_ready, rsp_valid, rf_rd, rf_wr, rf_addr, rf_data_in, rsp_rdata, rsp_err},
              21'd0);
        rst = 1'b0;
        tick();
        check("ready_after_release", cmd_ready, 1);

        // Reset in the middle of a write.
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 2'd1; cmd_wdata = 8'h55;
        tick();
        cmd_valid = 1'b0;
        check("midwr_strobe", rf_wr, 1);
        rst = 1'b1;
        tick();
        check("midwr_abort", {rf_wr, rf_rd, cmd_ready, rsp_valid}, 4'b0000);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("ready_after_midwr", cmd_ready, 1);
        repeat (3) tick();
        check("rsp_dropped", rsp_valid, 0);

        // Single write, then fill and read back.
        issue(2'b01, 2'd2, 8'h01, 3, 8'h00, 1'b0, 1, 0);
        issue(2'b01, 2'd0, 8'h00, 3, 8'h00, 1'b0, 1, 0);
        issue(2'b01, 2'd1, 8'h02, 3, 8'h00, 1'b0, 1, 0);
        issue(2'b01, 2'd2, 8'h01, 3, 8'h00, 1'b0, 1, 0);
        issue(2'b01, 2'd3, 8'h11, 3, 8'h00, 1'b0, 1, 0);
        issue(2'b00, 2'd0, 8'h00, 2, 8'h00, 1'b0, 0, 1);
        issue(2'b00, 2'd1, 8'h00, 2, 8'h02, 1'b0, 0, 1);
        issue(2'b00, 2'd2, 8'h00, 2, 8'h01, 1'b0, 0, 1);
        issue(2'b00, 2'd3, 8'h00, 2, 8'h11, 1'b0, 0, 1);

        // Clear-all: four write pulses on ascending addresses, then reads of zero.
        base = wr_cnt;
        issue(2'b10, 2'd2, 8'hA5, 9, 8'h00, 1'b0, 4, 0);
        for (int i = 0; i < 4; i++) check("clr_addr", wr_log[(base + i) % 64], i);
        for (int i = 0; i < 4; i++) issue(2'b00, 2'(i), 8'h00, 2, 8'h00, 1'b0, 0, 1);

        // Back-pressure on a read of addr 3 with a second read waiting.
        issue(2'b01, 2'd3, 8'h11, 3, 8'h00, 1'b0, 1, 0);
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 2'd3;
        tick();
        check("bp_busy", cmd_ready, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", {rsp_valid, cmd_ready, rf_rd, rsp_rdata}, {3'b100, 8'h11});
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_release", {rsp_valid, cmd_ready, rf_rd}, 3'b010);
        tick();
        cmd_valid = 1'b0;
        check("bp_second_accept", rf_rd, 1);
        tick();
        check("bp_second_rsp", {rsp_valid, rsp_rdata}, {1'b1, 8'h11});
        tick();

        // Illegal op, then a normal read.
        issue(2'b11, 2'd1, 8'h00, 1, 8'h00, 1'b1, 0, 0);
        issue(2'b00, 2'd3, 8'h00, 2, 8'h11, 1'b0, 0, 1);

        check("rd_wr_exclusive", both_cnt, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_master.md
Name: regfile_master

Overview:
- Initiator for the 4-entry x 8-bit register file port: addr, rd, wr, data_in, data_out.
- Accepts read, write and clear-all commands over a valid/ready handshake.
- Sequences rd/wr strobes with fixed timing and returns one response beat per command.
- Sits between the processor control/decode logic and the register file.

Parameters:
- DW, 8, data width of register file words.
- AW, 2, address width; register count = 2**AW.
- WR_CYCLES, 1, cycles rf_wr is held high per write (>=1).
- RD_LAT, 1, cycles rf_rd is held high before data capture (>=1).
- CLR_VAL, 8'h00, value written to every register by the clear-all command.

Ports:
- clk  in  1  clock, all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  00 read, 01 write, 10 clear-all, 11 illegal.
- cmd_addr  in  AW  target register.
- cmd_wdata  in  DW  write data.
- rsp_valid  out  1  response beat present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  DW  read data; 0 for non-read operations.
- rsp_err  out  1  1 for an illegal op.
- rf_addr  out  AW  to register file addr.
- rf_rd  out  1  to register file rd.
- rf_wr  out  1  to register file wr.
- rf_data_in  out  DW  to register file data_in.
- rf_data_out  in  DW  from register file data_out.

Behaviour:
- Reset: state IDLE; all outputs 0, including cmd_ready. cmd_ready rises the first cycle after rst is deasserted.
- Reset mid-operation: aborts the operation. rf_rd and rf_wr go 0 at that edge, and any pending response is dropped.
- States:
  - IDLE: cmd_ready=1; a handshake (cmd_valid & cmd_ready) latches op/addr/wdata.
  - WR: rf_wr=1 for WR_CYCLES.
  - WR_REC: one cycle, rf_wr=0, addr/data held.
  - RD: rf_rd=1 for RD_LAT.
  - CLR: loops WR/WR_REC over addresses 0..2**AW-1.
  - RSP: rsp_valid=1.
- cmd_ready=0 in every state except IDLE. Only one command is outstanding at a time.
- rf_addr and rf_data_in are stable for the entire strobe plus the recovery cycle. rf_rd and rf_wr are never both high.
- Write: with handshake at edge T, rf_wr=1 in cycles T+1..T+WR_CYCLES, then WR_REC, then rsp_valid. Defaults: rsp_valid in cycle T+3.
- Read: rf_rd=1 in cycles T+1..T+RD_LAT. rf_data_out is captured into rsp_rdata at the edge ending the last rd cycle. rsp_valid follows the next cycle (default T+2), and rf_rd=0 from that point.
- Clear-all: an AW-bit address counter runs from 0 to 2**AW-1. Each step is WR_CYCLES strobe + 1 recovery with rf_data_in=CLR_VAL. The counter wraps to 0 after the last address. Default: rsp_valid in cycle T+9.
- Illegal op: no strobes. Next cycle is RSP with rsp_err=1, rsp_rdata=0.
- RSP: rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready. On the handshake edge the controller returns to IDLE, rsp_valid=0 and cmd_ready=1 the following cycle. A new command cannot be accepted in the same cycle as the response handshake.
- Strobe counters are sized clog2(max(WR_CYCLES,RD_LAT))+1 and saturate-free: load on entry, decrement to 0.

Decomposition:
- Package regfile_master_pkg:
  - op encodings (OP_RD, OP_WR, OP_CLR, OP_ILL);
  - state enum (IDLE, WR, WR_REC, RD, CLR, RSP).
- One sub-module, regfile_master_timer: loadable down-counter with a done flag, shared by the WR and RD strobe timing.

Test Plan:
- Reset: hold rst 3 cycles mid-write -> rf_wr=0 at the reset edge, all outputs 0, cmd_ready=1 one cycle after release.
- Write: write addr 2, data 8'h01 -> rf_wr high exactly 1 cycle with rf_addr=2, rf_data_in=8'h01; rsp_valid at T+3, rsp_rdata=0, rsp_err=0.
- Read-back: write 8'h00/02/01/11 to addrs 0-3, then read 0..3 -> rsp_rdata 00, 02, 01, 11; rf_rd high 1 cycle each; rsp_valid at T+2.
- Clear-all: after the fills above, clear-all with CLR_VAL=8'h00 -> 4 wr pulses at addrs 0,1,2,3; rsp_valid at T+9; reads of all 4 registers return 8'h00.
- Back-pressure: hold rsp_ready=0 for 5 cycles after a read of addr 3 -> rsp_valid and rsp_rdata=8'h11 stable, cmd_ready=0 throughout; cmd_valid held high is not accepted until the cycle after the rsp handshake.
- Illegal op 11 -> no rf_rd/rf_wr activity, rsp_err=1 at T+1; the next read still works.
